mem_refill_ctrl: RTL and testbench

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

---
 rtl/refill_pkg.sv | 7 +
 rtl/refill_word_assembler.sv | 26 ++
 rtl/mem_refill_ctrl.sv | 75 +++++++
 tb/tb_mem_refill_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/refill_pkg.sv
// refill_pkg: shared FSM state type and block geometry for the cache refill controller
package refill_pkg;
  typedef enum logic [1:0] {IDLE, READ, DONE, ERR} state_t;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 128;
  localparam int OFFSET_BITS = 4;
endpackage

// File: rtl/refill_word_assembler.sv
// refill_word_assembler: word index counter and block register filled one word per handshake
module refill_word_assembler import refill_pkg::*; #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  wdata,
  output logic [1:0]         index,
  output logic               last,
  output logic [BLOCK_W-1:0] block
);
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
      block <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (wr_en) begin
      block[WORD_W*index +: WORD_W] <= wdata;
      index <= index + 2'd1;
    end
  end
  assign last = index == 2'(WORDS - 1);
endmodule

// File: rtl/mem_refill_ctrl.sv
// mem_refill_ctrl: fetches a 4-word cache block from main memory with per-word timeout.
// Define REFILL_MISS_COUNT_EN to add a saturating miss_count output.
module mem_refill_ctrl import refill_pkg::*; #(
  parameter int TIMEOUT = 64,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  output logic               busy,
  output logic               mem_rd,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  output logic               block_err
`ifdef REFILL_MISS_COUNT_EN
  ,
  output logic [31:0]        miss_count
`endif
);
  state_t state, next;
  logic [31:0] base, wcnt;
  logic [1:0] index;
  logic last, accept, capture, expire;
  assign accept = state == IDLE && miss_req;
  assign capture = state == READ && mem_ready;
  assign expire = state == READ && !mem_ready && wcnt == 32'(TIMEOUT - 1);
  always_comb begin
    next = state;
    busy = state != IDLE;
    mem_rd = state == READ;
    block_valid = state == DONE;
    block_err = state == ERR;
    mem_addr = base + 32'({index, 2'b00});
    case (state)
      IDLE: next = miss_req ? READ : IDLE;
      READ: next = capture && last ? DONE : expire ? ERR : READ;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      base <= '0;
      wcnt <= '0;
    end else begin
      state <= next;
      if (accept) begin
        base <= miss_addr & ~32'(2**OFFSET_BITS - 1);
        wcnt <= '0;
      end else if (state == READ) begin
        wcnt <= mem_ready ? '0 : wcnt + 32'd1;
      end
    end
  end
  refill_word_assembler #(.WORDS(WORDS)) u_asm (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .wr_en(capture),
    .wdata(mem_rdata),
    .index(index),
    .last(last),
    .block(block)
  );
`ifdef REFILL_MISS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) miss_count <= '0;
    else if (accept && miss_count != '1) miss_count <= miss_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// tb_mem_refill_ctrl: table-driven fetches plus timeout, reset and back-to-back sequences
module tb_mem_refill_ctrl;
  localparam int TO = 8;
  logic clk = 0, reset, miss_req, mem_ready;
  logic [31:0] miss_addr, mem_addr, mem_rdata;
  logic busy, mem_rd, block_valid, block_err;
  logic [127:0] block;
`ifdef REFILL_MISS_COUNT_EN
  logic [31:0] miss_count;
`endif
  int n_vec = 0, n_bad = 0, n_valid = 0, n_err = 0, n_acc = 0;
  logic [31:0] aq[$];
  logic [127:0] bq[$];
  typedef struct {
    logic [31:0]  addr;
    int           period;
    bit           poke;
    int           lat;
    logic [127:0] exp;
  } vec_t;
  vec_t vt[4];

  always #5 clk = ~clk;
  assign mem_rdata = mem_addr;

  mem_refill_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .block(block), .block_valid(block_valid), .block_err(block_err)
`ifdef REFILL_MISS_COUNT_EN
    , .miss_count(miss_count)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_blk(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  task automatic push_addrs(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) aq.push_back({a[31:4], 4'h0} + 32'(4 * i));
  endtask

  // scoreboard: handshakes and completed blocks popped in arrival order
  always @(negedge clk) begin
    if (mem_rd && mem_ready) begin
      if (aq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL mem_addr_unexpected: got %h want none", mem_addr);
      end else chk("mem_addr", 128'(mem_addr), 128'(aq.pop_front()));
    end
    if (block_valid) begin
      n_valid++;
      if (bq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL block_unexpected: got %h want none", block);
      end else chk("block", block, bq.pop_front());
    end
    if (block_err) n_err++;
  end

  task automatic run_fetch(input vec_t v);
    int c, v0;
    bit done;
    v0 = n_valid;
    miss_req = 1; miss_addr = v.addr; mem_ready = 0;
    push_addrs(v.addr, 4); bq.push_back(v.exp); n_acc++;
    tick();
    miss_req = 0;
    c = 1; done = 0;
    while (!done && c < 200) begin
      if (block_valid) done = 1;
      else begin
        chk("busy_fetch", 128'(busy), 128'(1));
        mem_ready = (c % v.period) == 0;
        miss_req = v.poke && c == 2;
        tick();
        c++;
      end
    end
    chk("latency", 128'(c), 128'(v.lat));
    chk("busy_done", 128'(busy), 128'(1));
    chk("mem_rd_done", 128'(mem_rd), 128'(0));
    mem_ready = 0; miss_req = 0;
    tick();
    chk("busy_idle", 128'(busy), 128'(0));
    chk("valid_once", 128'(n_valid - v0), 128'(1));
    chk("block_hold", block, v.exp);
  endtask

  initial begin
    vec_t v40;
    logic [127:0] prev;
    int v0, e0;
    vt[0] = '{32'h0000_1234, 1, 1'b0, 5, 128'h0000123C_00001238_00001234_00001230};
    vt[1] = '{32'hDEAD_BEEF, 3, 1'b0, 13, exp_blk(32'hDEAD_BEEF)};
    vt[2] = '{32'h0000_0000, 2, 1'b1, 9, exp_blk(32'h0)};
    vt[3] = '{32'hFFFF_FFF8, 1, 1'b1, 5, exp_blk(32'hFFFF_FFF8)};
    reset = 1; miss_req = 1; miss_addr = 32'h1234; mem_ready = 1;
    tick(); tick();
    chk("rst_block", block, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_mem_rd", 128'(mem_rd), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_valid", 128'(block_valid), 128'(0));
    chk("rst_err", 128'(block_err), 128'(0));
    reset = 0; miss_req = 0; mem_ready = 0;
    tick();
    for (int i = 0; i < 4; i++) run_fetch(vt[i]);

    // timeout with no word ever returned: ERR after TO READ cycles
    prev = block; v0 = n_valid; e0 = n_err;
    miss_req = 1; miss_addr = 32'h5000; n_acc++;
    tick();
    miss_req = 0;
    for (int c = 1; c <= TO; c++) begin
      chk("to_busy", 128'(busy), 128'(1));
      chk("to_mem_rd", 128'(mem_rd), 128'(1));
      chk("to_err_early", 128'(block_err), 128'(0));
      tick();
    end
    chk("to_err", 128'(block_err), 128'(1));
    chk("to_err_mem_rd", 128'(mem_rd), 128'(0));
    chk("to_err_busy", 128'(busy), 128'(1));
    chk("to_block_kept", block, prev);
    tick();
    chk("to_idle", 128'(busy), 128'(0));
    chk("to_err_once", 128'(n_err - e0), 128'(1));
    chk("to_no_valid", 128'(n_valid - v0), 128'(0));

    // miss_req held high: two fetches with one IDLE cycle between
    miss_req = 1; miss_addr = 32'h3000; mem_ready = 1;
    push_addrs(32'h3000, 4); push_addrs(32'h3010, 4);
    bq.push_back(exp_blk(32'h3000)); bq.push_back(exp_blk(32'h3010)); n_acc += 2;
    tick();
    miss_addr = 32'h3010;
    for (int c = 1; c <= 11; c++) begin
      if (c == 5 || c == 11) chk("b2b_valid", 128'(block_valid), 128'(1));
      if (c == 6) chk("b2b_idle", 128'(busy), 128'(0));
      if (c == 11) miss_req = 0;
      tick();
    end
    chk("b2b_end_idle", 128'(busy), 128'(0));
    mem_ready = 0;

    // reset while index is 2, with miss_req and mem_ready also high
    v0 = n_valid; e0 = n_err;
    miss_req = 1; miss_addr = 32'h2000; push_addrs(32'h2000, 3);
    tick();
    miss_req = 0; mem_ready = 1;
    tick(); tick();
    chk("mid_addr", 128'(mem_addr), 128'(32'h2008));
    reset = 1; miss_req = 1;
    tick();
    reset = 0; miss_req = 0; mem_ready = 0; n_acc = 0;
    chk("mid_block", block, 128'h0);
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_mem_rd", 128'(mem_rd), 128'(0));
    chk("mid_mem_addr", 128'(mem_addr), 128'(0));
    chk("mid_valid", 128'(block_valid), 128'(0));
    chk("mid_err", 128'(block_err), 128'(0));
    tick();
    chk("mid_no_pulses", 128'(n_valid - v0 + n_err - e0), 128'(0));
    v40 = '{32'h40, 1, 1'b0, 5, exp_blk(32'h40)};
    run_fetch(v40);
`ifdef REFILL_MISS_COUNT_EN
    chk("miss_count", 128'(miss_count), 128'(n_acc));
`endif
    chk("addr_queue_empty", 128'(aq.size()), 128'(0));
    chk("block_queue_empty", 128'(bq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
